// File: rtl/pkt_transmit_ctrl_pkg.sv
// Shared definitions for the transmit controller: word framing codes,
// label bit positions and the controller state encoding.
package pkt_transmit_ctrl_pkg;

  localparam int PKT_W = 139;
  localparam int LBL_W = 32;

  localparam logic [2:0] CODE_HEAD   = 3'b101;
  localparam logic [2:0] CODE_MIDDLE = 3'b100;
  localparam logic [2:0] CODE_TAIL   = 3'b110;

  localparam int LBL_LONG    = 31;
  localparam int LBL_NOBODY  = 30;
  localparam int LBL_CUT     = 29;
  localparam int LBL_CUTNO   = 28;
  localparam int LBL_AGING   = 27;
  localparam int LBL_ADDR_HI = 9;
  localparam int LBL_ADDR_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READ_LBL = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_WAIT_PKT = 2'd3
  } tx_state_e;

  function automatic logic is_tail(input logic [PKT_W-1:0] word);
    return word[PKT_W-1 -: 3] == CODE_TAIL;
  endfunction

endpackage

// File: rtl/pkt_transmit_ctrl_fifo.sv
// 16x32 label queue: show-ahead-free FIFO, q valid one cycle after rdreq,
// async clear, writes while full and reads while empty are ignored.
module fifo_32_16 (
  input  logic        clk,
  input  logic        aclr,
  input  logic [31:0] data,
  input  logic        wrreq,
  input  logic        rdreq,
  output logic [31:0] q,
  output logic [4:0]  usedw,
  output logic        full,
  output logic        empty
);

  logic [31:0] mem [16];
  logic [3:0]  wr_ptr_q;
  logic [3:0]  rd_ptr_q;
  logic [4:0]  count_q;
  logic [31:0] q_q;
  logic        wr_en;
  logic        rd_en;

  assign full  = (count_q == 5'd16);
  assign empty = (count_q == 5'd0);
  assign wr_en = wrreq && !full;
  assign rd_en = rdreq && !empty;
  assign usedw = count_q;
  assign q     = q_q;

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (rd_en) begin
        q_q      <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 4'd1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pkt_transmit_ctrl.sv
// Transmit controller: queues scheduler labels, issues one at a time to the
// packet buffer and forwards the returned word stream with one cycle of delay.
module pkt_transmit_ctrl
  import pkt_transmit_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16,
  parameter int LBL_AFULL = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sched_label_valid,
  input  logic [31:0]      sched_label,
  output logic             sched_label_enable,
  output logic             t2pb_label_valid,
  output logic [31:0]      t2pb_label,
  input  logic             pb2t_enable,
  input  logic             pb2t_pkt_valid,
  input  logic [138:0]     pb2t_pkt,
  input  logic             tx_enable,
  output logic             tx_pkt_valid,
  output logic [138:0]     tx_pkt,
  output logic [CNT_W-1:0] tx_pkt_cnt,
  output logic [CNT_W-1:0] nobody_drop_cnt,
  output logic [CNT_W-1:0] err_timeout_cnt,
  output logic [CNT_W-1:0] stray_word_cnt
);

  localparam int         TMR_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [4:0]       AFULL_LVL = 5'(LBL_AFULL);

  tx_state_e         state_q, state_d;
  logic [LBL_W-1:0]  label_q, label_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  nobody_q, nobody_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic [CNT_W-1:0]  stray_q, stray_d;
  logic              enable_q;
  logic              tx_valid_q;
  logic [PKT_W-1:0]  tx_pkt_q;

  logic [31:0]       fifo_q;
  logic [4:0]        fifo_usedw;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rdreq;
  logic              forward;

  fifo_32_16 u_label_fifo (
    .clk   (clk),
    .aclr  (!reset),
    .data  (sched_label),
    .wrreq (sched_label_valid),
    .rdreq (fifo_rdreq),
    .q     (fifo_q),
    .usedw (fifo_usedw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign forward = pb2t_pkt_valid && (state_q == ST_WAIT_PKT);

  always_comb begin
    state_d          = state_q;
    label_d          = label_q;
    timer_d          = timer_q;
    tx_cnt_d         = tx_cnt_q;
    nobody_d         = nobody_q;
    timeout_d        = timeout_q;
    stray_d          = stray_q;
    fifo_rdreq       = 1'b0;
    t2pb_label_valid = 1'b0;

    if (pb2t_pkt_valid && (state_q != ST_WAIT_PKT)) stray_d = stray_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && pb2t_enable && tx_enable) begin
          fifo_rdreq = 1'b1;
          state_d    = ST_READ_LBL;
        end
      end
      ST_READ_LBL: begin
        label_d = fifo_q;
        if (fifo_q[LBL_NOBODY]) begin
          nobody_d = nobody_q + CNT_W'(1);
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        t2pb_label_valid = 1'b1;
        timer_d          = '0;
        state_d          = ST_WAIT_PKT;
      end
      ST_WAIT_PKT: begin
        timer_d = timer_q + TMR_W'(1);
        // A tail arriving on the timeout cycle still counts as a good packet.
        if (forward && is_tail(pb2t_pkt)) begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
          state_d  = ST_IDLE;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = timeout_q + CNT_W'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      label_q    <= '0;
      timer_q    <= '0;
      tx_cnt_q   <= '0;
      nobody_q   <= '0;
      timeout_q  <= '0;
      stray_q    <= '0;
      enable_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_pkt_q   <= '0;
    end else begin
      state_q    <= state_d;
      label_q    <= label_d;
      timer_q    <= timer_d;
      tx_cnt_q   <= tx_cnt_d;
      nobody_q   <= nobody_d;
      timeout_q  <= timeout_d;
      stray_q    <= stray_d;
      enable_q   <= (fifo_usedw < AFULL_LVL) && !fifo_full;
      tx_valid_q <= forward;
      if (forward) tx_pkt_q <= pb2t_pkt;
    end
  end

  assign sched_label_enable = enable_q;
  assign t2pb_label         = label_q;
  assign tx_pkt_valid       = tx_valid_q;
  assign tx_pkt             = tx_pkt_q;
  assign tx_pkt_cnt         = tx_cnt_q;
  assign nobody_drop_cnt    = nobody_q;
  assign err_timeout_cnt    = timeout_q;
  assign stray_word_cnt     = stray_q;

endmodule
